// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode constants, fetch queue entry, fetch FSM states.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StHalt = 1'b1
    } fetch_state_e;

    // ecall/ebreak and the CSR instructions all share the SYSTEM major opcode
    function automatic logic is_system(input logic [31:0] instr);
        return instr[6:0] == OPC_SYSTEM;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of {pc, instr} fetch entries with synchronous flush.
// Pointers carry an extra MSB so full and empty are distinguishable; the head
// is read straight from storage, so a push only becomes visible the next cycle.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    output fetch_entry_t             head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    fetch_entry_t mem_q [DEPTH];
    logic         full;

    // Pointer update; flush wins over any same-cycle push or pop
    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Entry storage, written at the tail slot
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    // Status and head decode
    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count_o = wr_ptr_q - rd_ptr_q;
        head_o  = mem_q[rd_ptr_q[AW-1:0]];
    end

    a_no_push_full:  assert property (@(posedge clk_i) disable iff (flush_i) !(push_i && full));
    a_no_pop_empty:  assert property (@(posedge clk_i) disable iff (flush_i) !(pop_i && empty_o));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues 1-cycle-latency imem reads under a
// queue credit, buffers responses for decode, and handles redirects and SYSTEM halts.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     dec_valid,
    output logic [31:0]              dec_instr,
    output logic [31:0]              dec_pc,
    input  logic                     dec_ready,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          inflight_q;
    logic [31:0]   inflight_pc_q, inflight_pc_d;

    logic [31:0]   redirect_addr;
    logic          halt_now;
    logic [CW-1:0] eff_count;
    logic          credit_ok;
    logic          fq_push, fq_pop, fq_flush, fq_empty;
    logic [CW-1:0] fq_count;
    fetch_entry_t  fq_head, fq_push_data;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Issue, halt detection and decode-side handshake
    always_comb begin
        redirect_addr = {redirect_pc[31:2], 2'b00};
        halt_now      = inflight_q && is_system(imem_rdata) && !redirect_valid;
        // A redirect empties the queue, so it regains the full credit; a same-cycle pop does not
        eff_count     = redirect_valid ? '0 : fq_count;
        credit_ok     = ({1'b0, eff_count} + {{CW{1'b0}}, inflight_q}) < DepthW;
        // A redirect always restarts fetch, even out of the halted state
        imem_req      = !reset && credit_ok &&
                        (redirect_valid || (state_q == StRun && !halt_now));
        imem_addr     = redirect_valid ? redirect_addr : pc_q;

        fq_flush      = reset || redirect_valid;
        fq_push       = inflight_q && !redirect_valid && !reset;
        fq_push_data  = '{pc: inflight_pc_q, instr: imem_rdata};
        dec_valid     = !reset && !fq_empty && !redirect_valid;
        fq_pop        = dec_valid && dec_ready;
        dec_pc        = fq_head.pc;
        dec_instr     = fq_head.instr;
        queue_count   = reset ? '0 : fq_count;
        halted        = (state_q == StHalt);
    end

    // Next PC and fetch side register
    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        if (imem_req) begin
            pc_d          = imem_addr + 32'd4;
            inflight_pc_d = imem_addr;
        end
    end

    // Run/halt next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (halt_now)       state_d = StHalt;
            StHalt:  if (redirect_valid) state_d = StRun;
            default:                     state_d = StRun;
        endcase
    end

    // Fetch state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= imem_req;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk_i       (clk),
        .flush_i     (fq_flush),
        .push_i      (fq_push),
        .push_data_i (fq_push_data),
        .pop_i       (fq_pop),
        .head_o      (fq_head),
        .empty_o     (fq_empty),
        .count_o     (fq_count)
    );

    a_dec_stable: assert property (@(posedge clk) disable iff (reset)
        (dec_valid && !dec_ready) |=> (reset || redirect_valid ||
            (dec_valid && dec_pc == $past(dec_pc) && dec_instr == $past(dec_instr))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset, dec_ready, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req, dec_valid, halted;
    logic [31:0] imem_addr, imem_rdata, dec_instr, dec_pc;
    logic [2:0]  queue_count;

    logic        reset2;
    logic        ready2 = 1'b1, redir2 = 1'b0;
    logic [31:0] rp2 = 32'h0;
    logic        req2, dv2, halted2;
    logic [31:0] addr2, rdata2, instr2, pc2;
    logic [2:0]  qc2;

    int n_cmp = 0;
    int n_bad = 0;

    bit          sys_rand = 1'b0;
    bit          ecall_en = 1'b0;
    logic [31:0] ecall_addr = 32'h0;

    ent_t        mq[$];
    logic [31:0] m_pc = 32'h0, m_infl_pc = 32'h0;
    bit          m_infl = 1'b0, m_halted = 1'b0;

    logic        s_req, s_dv, s_halted, s_req2, s_dv2, s_halted2;
    logic [31:0] s_addr, s_pc, s_instr, s_addr2, s_pc2, s_instr2;
    logic [2:0]  s_count;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_instr(dec_instr),
        .dec_pc(dec_pc), .dec_ready(dec_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halted(halted), .queue_count(queue_count)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut2 (
        .clk(clk), .reset(reset2), .imem_req(req2), .imem_addr(addr2),
        .imem_rdata(rdata2), .dec_valid(dv2), .dec_instr(instr2),
        .dec_pc(pc2), .dec_ready(ready2), .redirect_valid(redir2),
        .redirect_pc(rp2), .halted(halted2), .queue_count(qc2)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        logic [31:0] h;
        h = (a >> 2) * 32'h9E37_79B1;
        if (ecall_en && a == ecall_addr) return 32'h0000_0073;
        if (sys_rand && h[31:27] == 5'd0) return 32'h0010_0073;
        return {a[24:0] ^ 25'h1AB_CDE5, 7'b0010011};
    endfunction

    function automatic logic [31:0] mem2_fn(input logic [31:0] a);
        return {a[24:0], 7'b0010011};
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_fn(imem_addr);
        if (req2)     rdata2     <= mem2_fn(addr2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance the model
    task automatic cycle();
        logic [31:0] rd, ea;
        bit          hn, er, edv;
        int          ec;
        @(negedge clk);
        s_req = imem_req; s_addr = imem_addr; s_dv = dec_valid; s_pc = dec_pc;
        s_instr = dec_instr; s_count = queue_count; s_halted = halted;
        s_req2 = req2; s_addr2 = addr2; s_dv2 = dv2; s_pc2 = pc2; s_instr2 = instr2;
        s_halted2 = halted2;
        rd = 32'h0; ea = 32'h0; hn = 1'b0; er = 1'b0; edv = 1'b0;
        if (reset) begin
            chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
            chk("rst_dec_valid", {31'h0, dec_valid}, 32'h0);
            chk("rst_queue_count", {29'h0, queue_count}, 32'h0);
            mq.delete();
            m_pc = 32'h0; m_infl = 1'b0; m_infl_pc = 32'h0; m_halted = 1'b0;
        end else begin
            rd  = mem_fn(m_infl_pc);
            hn  = m_infl && rd[6:0] == 7'b1110011 && !redirect_valid;
            ec  = redirect_valid ? 0 : mq.size();
            er  = (ec + int'(m_infl) < DEPTH) && (redirect_valid || (!m_halted && !hn));
            ea  = redirect_valid ? {redirect_pc[31:2], 2'b00} : m_pc;
            edv = mq.size() > 0 && !redirect_valid;
            chk("imem_req", {31'h0, imem_req}, {31'h0, er});
            if (er) chk("imem_addr", imem_addr, ea);
            chk("dec_valid", {31'h0, dec_valid}, {31'h0, edv});
            if (edv) begin
                chk("dec_pc", dec_pc, mq[0].pc);
                chk("dec_instr", dec_instr, mq[0].instr);
            end
            chk("halted", {31'h0, halted}, {31'h0, m_halted});
            chk("queue_count", {29'h0, queue_count}, mq.size());
            if (redirect_valid) begin
                mq.delete();
                m_halted = 1'b0;
            end else begin
                if (edv && dec_ready) void'(mq.pop_front());
                if (m_infl) mq.push_back('{pc: m_infl_pc, instr: rd});
                if (hn) m_halted = 1'b1;
            end
            m_infl = er;
            if (er) begin
                m_pc      = ea + 32'd4;
                m_infl_pc = ea;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1; dec_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        #1;
        repeat (3) cycle();

        // Sequential fetch from reset, decode always ready
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i == 0) chk("t1_addr_c0", s_addr, 32'h0);
            if (i == 1) chk("t1_addr_c1", s_addr, 32'h4);
            if (i == 1) chk("t1_dv_c1", {31'h0, s_dv}, 32'h0);
            if (i == 2) chk("t1_addr_c2", s_addr, 32'h8);
            if (i == 2) chk("t1_pc_c2", s_pc, 32'h0);
            if (i == 3) chk("t1_pc_c3", s_pc, 32'h4);
            if (i == 4) chk("t1_pc_c4", s_pc, 32'h8);
        end

        // Backpressure saturation, then drain
        reset = 1'b1; cycle(); reset = 1'b0; dec_ready = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("t2_count_sat", {29'h0, s_count}, 32'd4);
        chk("t2_req_drop", {31'h0, s_req}, 32'h0);
        chk("t2_head_pc", s_pc, 32'h0);
        dec_ready = 1'b1;
        cycle();
        chk("t2_rel_pc0", s_pc, 32'h0);
        chk("t2_rel_req0", {31'h0, s_req}, 32'h0);
        cycle();
        chk("t2_rel_pc1", s_pc, 32'h4);
        chk("t2_rel_addr1", s_addr, 32'h10);
        repeat (8) cycle();

        // Reset with a full queue
        dec_ready = 1'b0;
        repeat (8) cycle();
        chk("t6_full", {29'h0, s_count}, 32'd4);
        reset = 1'b1; cycle();
        chk("t6_rst_count", {29'h0, s_count}, 32'h0);
        reset = 1'b0; cycle();
        chk("t6_post_count", {29'h0, s_count}, 32'h0);
        chk("t6_post_dv", {31'h0, s_dv}, 32'h0);
        chk("t6_post_addr", s_addr, 32'h0);
        dec_ready = 1'b1;
        repeat (4) cycle();

        // Redirect with three queued and one in flight
        reset = 1'b1; cycle(); reset = 1'b0; dec_ready = 1'b0;
        repeat (4) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        cycle();
        chk("t3_count", {29'h0, s_count}, 32'd3);
        chk("t3_dv", {31'h0, s_dv}, 32'h0);
        chk("t3_addr", s_addr, 32'h100);
        redirect_valid = 1'b0; dec_ready = 1'b1;
        cycle();
        chk("t3_dv_next", {31'h0, s_dv}, 32'h0);
        cycle();
        chk("t3_pc_new", s_pc, 32'h100);
        repeat (4) cycle();

        // ecall at 0x8 halts fetch; redirect resumes
        reset = 1'b1; ecall_en = 1'b1; ecall_addr = 32'h8; cycle(); reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i == 3) chk("t4_no_fetch_c", {31'h0, s_req}, 32'h0);
            if (i == 4) chk("t4_halted", {31'h0, s_halted}, 32'h1);
            if (i == 4) chk("t4_pc8", s_pc, 32'h8);
            if (i == 4) chk("t4_instr", s_instr, 32'h73);
            if (i == 5) chk("t4_req_halt", {31'h0, s_req}, 32'h0);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cycle();
        chk("t4_redir_req", {31'h0, s_req}, 32'h1);
        chk("t4_redir_addr", s_addr, 32'h40);
        redirect_valid = 1'b0;
        cycle();
        chk("t4_unhalt", {31'h0, s_halted}, 32'h0);
        cycle();
        chk("t4_pc40", s_pc, 32'h40);

        // PC wrap on the second instance
        reset2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i == 0) chk("t5_addr0", s_addr2, 32'hFFFF_FFF8);
            if (i == 1) chk("t5_addr1", s_addr2, 32'hFFFF_FFFC);
            if (i == 2) chk("t5_addr2", s_addr2, 32'h0);
            if (i == 2) chk("t5_pc2", s_pc2, 32'hFFFF_FFF8);
            if (i == 2) chk("t5_instr2", s_instr2, mem2_fn(32'hFFFF_FFF8));
            if (i == 3) chk("t5_pc3", s_pc2, 32'hFFFF_FFFC);
            if (i == 4) chk("t5_pc4", s_pc2, 32'h0);
            if (i == 4) chk("t5_dv4", {31'h0, s_dv2}, 32'h1);
            if (i == 5) chk("t5_halted", {31'h0, s_halted2}, 32'h0);
        end

        // Randomized traffic
        reset = 1'b1; ecall_en = 1'b0; sys_rand = 1'b1; cycle(); reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            dec_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = m_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 31) == 0);
            redirect_pc    = $urandom_range(0, 1023) | (($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 : 32'h0);
            reset          = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
